// File: rtl/num_extend.sv
// num_extend: registered sign/zero extender, IN_W-bit num + sign + valid in, OUT_W-bit num + valid out, 1-cycle latency
module num_extend #(
  parameter int IN_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             i_NumExtend_clk,
  input  logic             i_NumExtend_rst_n,
  input  logic [IN_W-1:0]  i_NumExtend_num,
  input  logic             i_NumExtend_sign,
  input  logic             i_NumExtend_valid,
  output logic [OUT_W-1:0] o_NumExtend_num,
  output logic             o_NumExtend_valid
);
  logic [OUT_W-1:0] extNum;
  generate
    if (OUT_W <= IN_W) begin : g_badWidth
      $error("num_extend requires OUT_W > IN_W");
    end
  endgenerate
  always_comb extNum = {{(OUT_W-IN_W){i_NumExtend_sign & i_NumExtend_num[IN_W-1]}}, i_NumExtend_num};
  always_ff @(posedge i_NumExtend_clk or negedge i_NumExtend_rst_n)
    if (!i_NumExtend_rst_n) begin
      o_NumExtend_num <= '0;
      o_NumExtend_valid <= 1'b0;
    end else begin
      o_NumExtend_valid <= i_NumExtend_valid;
      if (i_NumExtend_valid) o_NumExtend_num <= extNum;
    end
endmodule

// File: tb/tb_num_extend.sv
// tb_num_extend: directed and random checks of num_extend against an arithmetic reference model
module tb_num_extend;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [15:0] num = '0;
  logic sign = 1'b0;
  logic valid = 1'b0;
  logic [31:0] outNum;
  logic outValid;
  logic [31:0] expNum = '0;
  logic expValid = 1'b0;
  int errors = 0;
  int checks = 0;

  num_extend #(.IN_W(16), .OUT_W(32)) dut (
    .i_NumExtend_clk(clk),
    .i_NumExtend_rst_n(rstN),
    .i_NumExtend_num(num),
    .i_NumExtend_sign(sign),
    .i_NumExtend_valid(valid),
    .o_NumExtend_num(outNum),
    .o_NumExtend_valid(outValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refExt(logic [15:0] n, logic s);
    return (s && n >= 16'h8000) ? 32'(n) + 32'hFFFF0000 : 32'(n);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic [15:0] n, logic s, logic v);
    @(negedge clk);
    num = n;
    sign = s;
    valid = v;
    @(posedge clk);
    #1;
    if (rstN) begin
      if (v) expNum = refExt(n, s);
      expValid = v;
    end
    check({tag, ".num"}, outNum, expNum);
    check({tag, ".valid"}, 32'(outValid), 32'(expValid));
  endtask

  initial begin
    #2;
    check("reset.num", outNum, 32'h0);
    check("reset.valid", 32'(outValid), 32'h0);
    step("rst_hold", 16'hFFFF, 1'b1, 1'b1);
    step("rst_hold2", 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    rstN = 1'b1;
    valid = 1'b0;
    step("first_after_rst", 16'h1234, 1'b1, 1'b1);
    check("first_after_rst.lit", outNum, 32'h00001234);
    step("s026", 16'hF234, 1'b0, 1'b1);
    check("s026.lit", outNum, 32'h0000F234);
    step("s027", 16'h0234, 1'b0, 1'b1);
    check("s027.lit", outNum, 32'h00000234);
    step("s029", 16'h0234, 1'b1, 1'b1);
    check("s029.lit", outNum, 32'h00000234);
    step("s028", 16'hF234, 1'b1, 1'b1);
    check("s028.lit", outNum, 32'hFFFFF234);
    step("hold0", 16'h0001, 1'b0, 1'b0);
    step("hold1", 16'h8001, 1'b1, 1'b0);
    step("hold2", 16'h7777, 1'b0, 1'b0);
    check("hold.lit", outNum, 32'hFFFFF234);
    step("reload", 16'hF234, 1'b1, 1'b1);
    @(negedge clk);
    valid = 1'b1;
    num = 16'h0F0F;
    #2;
    rstN = 1'b0;
    #1;
    expNum = '0;
    expValid = 1'b0;
    check("midrst.num", outNum, 32'h0);
    check("midrst.valid", 32'(outValid), 32'h0);
    step("midrst_hold", 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    rstN = 1'b1;
    step("zero_s1", 16'h0000, 1'b1, 1'b1);
    check("zero_s1.lit", outNum, 32'h0);
    step("zero_s0", 16'h0000, 1'b0, 1'b1);
    step("ones_s1", 16'hFFFF, 1'b1, 1'b1);
    check("ones_s1.lit", outNum, 32'hFFFFFFFF);
    step("ones_s0", 16'hFFFF, 1'b0, 1'b1);
    check("ones_s0.lit", outNum, 32'h0000FFFF);
    step("min_s1", 16'h8000, 1'b1, 1'b1);
    check("min_s1.lit", outNum, 32'hFFFF8000);
    step("max_s1", 16'h7FFF, 1'b1, 1'b1);
    check("max_s1.lit", outNum, 32'h00007FFF);
    for (int i = 0; i < 300; i++)
      step("rand", 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/num_extend.md
NUM_EXTEND -- requirements
Module: num_extend

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, input immediate width.
REQ-002 The block SHALL have parameter OUT_W, default 32, output width; the block SHALL require OUT_W > IN_W.
REQ-003 The block SHALL have port i_NumExtend_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_NumExtend_rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_NumExtend_num, input, IN_W bits, immediate to extend.
REQ-006 The block SHALL have port i_NumExtend_sign, input, 1 bit; 1 selects sign extension, 0 selects zero extension.
REQ-007 The block SHALL have port i_NumExtend_valid, input, 1 bit, qualifies num/sign for capture.
REQ-008 The block SHALL have port o_NumExtend_num, output, OUT_W bits, registered extended value.
REQ-009 The block SHALL have port o_NumExtend_valid, output, 1 bit, high when o_NumExtend_num holds a result captured on the previous edge.

Function
REQ-010 Extension: bits [IN_W-1:0] of the result SHALL equal i_NumExtend_num unchanged.
REQ-011 Bits [OUT_W-1:IN_W] of the result SHALL all be i_NumExtend_num[IN_W-1] when sign=1, else all 0.
REQ-012 Latency SHALL be exactly one clock: a result captured on edge N SHALL appear on o_NumExtend_num right after edge N.
REQ-013 On each rising edge with valid=1, the block SHALL load o_NumExtend_num with the extended value and set o_NumExtend_valid=1.
REQ-014 On each rising edge with valid=0, the block SHALL hold o_NumExtend_num at its previous value and clear o_NumExtend_valid to 0.
REQ-015 The block SHALL accept back-to-back valid inputs every cycle with no stall; it SHALL have no backpressure.
REQ-016 The block SHALL sample sign and num together on the same edge; a sign change without valid SHALL NOT affect the output.
REQ-017 Boundary: num=0 SHALL produce 0 for either sign setting.
REQ-018 Boundary: num with MSB=1 and all ones (16'hFFFF) SHALL produce all ones when sign=1 and 32'h0000FFFF when sign=0.
REQ-019 Boundary: num=16'h8000 with sign=1 SHALL produce 32'hFFFF8000.
REQ-020 Boundary: num=16'h7FFF with sign=1 SHALL produce 32'h00007FFF.
REQ-021 The block SHALL contain no X-propagation paths: outputs SHALL be defined whenever reset has been applied once.

Reset
REQ-022 When i_NumExtend_rst_n=0, the block SHALL immediately, without waiting for a clock, force o_NumExtend_num=0 and o_NumExtend_valid=0.
REQ-023 The block SHALL hold both outputs at 0 while reset is low, regardless of valid.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-025 After rst_n deasserts, the first valid input SHALL be captured on the next rising edge.

Verification
REQ-026 Scenario: num=16'hF234, sign=0, valid=1 -> o_NumExtend_num=32'h0000F234 and o_NumExtend_valid=1 after one edge.
REQ-027 Scenario: num=16'h0234, sign=0, valid=1 -> 32'h00000234.
REQ-028 Scenario: num=16'hF234, sign=1, valid=1 -> 32'hFFFFF234.
REQ-029 Scenario: num=16'h0234, sign=1, valid=1 -> 32'h00000234.
REQ-030 Scenario: after the REQ-028 result, valid=0 for 3 cycles with num changing -> output held at 32'hFFFFF234 and o_NumExtend_valid=0.
REQ-031 Scenario: rst_n pulled low between clock edges while output=32'hFFFFF234 -> output and valid go to 0 at once; the boundary values of REQ-018 to REQ-020 are checked after release.
